// File: rtl/truth_table_lut_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : truth_table_lut_seq_if
//  Brief    : Config-load, evaluate and sweep handshake bundle for the LUT gate.
//  Revision : 1.0  initial release
// ============================================================================
interface truth_table_lut_seq_if #(
  parameter int N_INPUTS = 4
);
  logic                cfg_start;
  logic                cfg_valid;
  logic                cfg_bit;
  logic                cfg_ready;
  logic                cfg_done;
  logic                eval_valid;
  logic [N_INPUTS-1:0] eval_in;
  logic                eval_ready;
  logic                sweep_start;
  logic                sweep_busy;
  logic                sweep_done;
  logic                out_valid;
  logic                out;
  logic [N_INPUTS-1:0] out_row;
  logic [N_INPUTS:0]   ones_count;

  modport master (
    output cfg_start, cfg_valid, cfg_bit, eval_valid, eval_in, sweep_start,
    input  cfg_ready, cfg_done, eval_ready, sweep_busy, sweep_done,
           out_valid, out, out_row, ones_count
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_bit, eval_valid, eval_in, sweep_start,
    output cfg_ready, cfg_done, eval_ready, sweep_busy, sweep_done,
           out_valid, out, out_row, ones_count
  );
endinterface
`default_nettype wire

// File: rtl/truth_table_lut_seq.sv
`default_nettype none
// ============================================================================
//  Module   : truth_table_lut_seq
//  Brief    : Run-time loadable N-input truth-table gate with registered eval
//             and full-table sweep.
//  Revision : 1.0  initial release
// ============================================================================
module truth_table_lut_seq #(
  parameter int N_INPUTS = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  truth_table_lut_seq_if.slave  bus
);
  localparam int                  ROWS       = 1 << N_INPUTS;
  localparam logic [N_INPUTS-1:0] c_LAST_ROW = N_INPUTS'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SWEEP = 2'd2
  } state_t;

  state_t              r_state;
  logic [ROWS-1:0]     r_shadow;
  logic [ROWS-1:0]     r_active;
  logic [N_INPUTS-1:0] r_bit_cnt;
  logic [N_INPUTS-1:0] r_row_cnt;
  logic [N_INPUTS-1:0] r_out_row;
  logic [N_INPUTS:0]   r_ones_count;
  logic                r_cfg_done;
  logic                r_sweep_busy;
  logic                r_sweep_done;
  logic                r_out_valid;
  logic                r_out;

  logic [ROWS-1:0]     w_shadow_next;
  logic                w_idle_start;
  logic                w_eval_ready;
  logic                w_eval_fire;

  assign w_idle_start = (r_state == S_IDLE) && (bus.cfg_start || bus.sweep_start);
  assign w_eval_ready = (r_state != S_SWEEP) && !w_idle_start;
  assign w_eval_fire  = bus.eval_valid && w_eval_ready;

  // Shadow with the incoming bit merged, so a commit includes the final bit.
  always_comb begin
    w_shadow_next            = r_shadow;
    w_shadow_next[r_bit_cnt] = bus.cfg_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_shadow     <= '0;
      r_active     <= '0;
      r_bit_cnt    <= '0;
      r_row_cnt    <= '0;
      r_out_row    <= '0;
      r_ones_count <= '0;
      r_cfg_done   <= 1'b0;
      r_sweep_busy <= 1'b0;
      r_sweep_done <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out        <= 1'b0;
    end else begin
      r_cfg_done  <= 1'b0;
      r_out_valid <= 1'b0;

      if (w_eval_fire) begin
        r_out_valid <= 1'b1;
        r_out       <= r_active[bus.eval_in];
        r_out_row   <= bus.eval_in;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.cfg_start) begin
            r_state   <= S_LOAD;
            r_bit_cnt <= '0;
          end else if (bus.sweep_start) begin
            // Row 0 is registered here so it appears the cycle after the request.
            r_state      <= S_SWEEP;
            r_sweep_busy <= 1'b1;
            r_sweep_done <= 1'b0;
            r_out_valid  <= 1'b1;
            r_out        <= r_active[0];
            r_out_row    <= '0;
            r_ones_count <= {{N_INPUTS{1'b0}}, r_active[0]};
            r_row_cnt    <= N_INPUTS'(1);
          end
        end

        S_LOAD: begin
          if (bus.cfg_start) begin
            r_bit_cnt <= '0;
          end else if (bus.cfg_valid) begin
            r_shadow  <= w_shadow_next;
            r_bit_cnt <= r_bit_cnt + N_INPUTS'(1);
            if (r_bit_cnt == c_LAST_ROW) begin
              r_active   <= w_shadow_next;
              r_cfg_done <= 1'b1;
              r_state    <= S_IDLE;
            end
          end
        end

        S_SWEEP: begin
          if (r_sweep_done) begin
            r_state      <= S_IDLE;
            r_sweep_busy <= 1'b0;
            r_sweep_done <= 1'b0;
          end else begin
            r_out_valid  <= 1'b1;
            r_out        <= r_active[r_row_cnt];
            r_out_row    <= r_row_cnt;
            r_ones_count <= r_ones_count + {{N_INPUTS{1'b0}}, r_active[r_row_cnt]};
            r_sweep_done <= (r_row_cnt == c_LAST_ROW);
            r_row_cnt    <= r_row_cnt + N_INPUTS'(1);
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cfg_ready  = (r_state == S_LOAD);
  assign bus.cfg_done   = r_cfg_done;
  assign bus.eval_ready = w_eval_ready;
  assign bus.sweep_busy = r_sweep_busy;
  assign bus.sweep_done = r_sweep_done;
  assign bus.out_valid  = r_out_valid;
  assign bus.out        = r_out;
  assign bus.out_row    = r_out_row;
  assign bus.ones_count = r_ones_count;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_lut_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_truth_table_lut_seq
//  Brief    : Directed bench for truth_table_lut_seq at N_INPUTS = 4, 2 and 6.
//  Revision : 1.0  initial release
// ============================================================================
module tb_truth_table_lut_seq;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cur_n        = 4;

  always #5 clk = ~clk;

  truth_table_lut_seq_if #(.N_INPUTS(4)) bus4 ();
  truth_table_lut_seq_if #(.N_INPUTS(2)) bus2 ();
  truth_table_lut_seq_if #(.N_INPUTS(6)) bus6 ();

  truth_table_lut_seq #(.N_INPUTS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  truth_table_lut_seq #(.N_INPUTS(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  truth_table_lut_seq #(.N_INPUTS(6)) u_dut6 (.clk(clk), .rst_n(rst_n), .bus(bus6.slave));

  typedef struct packed {
    logic       cfg_ready;
    logic       cfg_done;
    logic       eval_ready;
    logic       sweep_busy;
    logic       sweep_done;
    logic       out_valid;
    logic       out;
    logic [7:0] out_row;
    logic [8:0] ones_count;
  } obs_t;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s (N=%0d): got 0x%0h, expected 0x%0h", tag, cur_n, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input logic cs, input logic cv, input logic cb,
                       input logic ev, input logic [7:0] ein, input logic ss);
    case (w)
      2: begin
        bus2.cfg_start = cs; bus2.cfg_valid = cv; bus2.cfg_bit = cb;
        bus2.eval_valid = ev; bus2.eval_in = ein[1:0]; bus2.sweep_start = ss;
      end
      6: begin
        bus6.cfg_start = cs; bus6.cfg_valid = cv; bus6.cfg_bit = cb;
        bus6.eval_valid = ev; bus6.eval_in = ein[5:0]; bus6.sweep_start = ss;
      end
      default: begin
        bus4.cfg_start = cs; bus4.cfg_valid = cv; bus4.cfg_bit = cb;
        bus4.eval_valid = ev; bus4.eval_in = ein[3:0]; bus4.sweep_start = ss;
      end
    endcase
  endtask

  task automatic idle(input int w);
    drive(w, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  function automatic obs_t sample(input int w);
    obs_t o;
    case (w)
      2: o = '{bus2.cfg_ready, bus2.cfg_done, bus2.eval_ready, bus2.sweep_busy,
               bus2.sweep_done, bus2.out_valid, bus2.out,
               {6'b0, bus2.out_row}, {6'b0, bus2.ones_count}};
      6: o = '{bus6.cfg_ready, bus6.cfg_done, bus6.eval_ready, bus6.sweep_busy,
               bus6.sweep_done, bus6.out_valid, bus6.out,
               {2'b0, bus6.out_row}, {2'b0, bus6.ones_count}};
      default: o = '{bus4.cfg_ready, bus4.cfg_done, bus4.eval_ready, bus4.sweep_busy,
                     bus4.sweep_done, bus4.out_valid, bus4.out,
                     {4'b0, bus4.out_row}, {4'b0, bus4.ones_count}};
    endcase
    return o;
  endfunction

  task automatic eval(input int w, input int row, input logic exp);
    obs_t o;
    drive(w, 1'b0, 1'b0, 1'b0, 1'b1, 8'(row), 1'b0);
    step();
    idle(w);
    o = sample(w);
    check("eval", 64'({o.out_valid, o.out, o.out_row}), 64'({1'b1, exp, 8'(row)}));
    step();
    o = sample(w);
    check("eval_hold", 64'({o.out_valid, o.out, o.out_row}), 64'({1'b0, exp, 8'(row)}));
  endtask

  task automatic load(input int w, input logic [63:0] tbl, input int nbits, input bit do_start,
                      input int ev_at, input int ev_row, input logic ev_exp);
    int   rows = 1 << w;
    obs_t o;
    bit   early_bad = 1'b0;
    if (do_start) begin
      drive(w, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      step();
      idle(w);
    end
    o = sample(w);
    check("load_ready", 64'(o.cfg_ready), 64'(1'b1));
    for (int i = 0; i < nbits; i++) begin
      drive(w, 1'b0, 1'b1, tbl[i], (i == ev_at), 8'(ev_row), 1'b0);
      step();
      idle(w);
      o = sample(w);
      if (i == ev_at)
        check("load_eval", 64'({o.out_valid, o.out, o.out_row}), 64'({1'b1, ev_exp, 8'(ev_row)}));
      if (i < rows - 1 && (o.cfg_done !== 1'b0 || o.cfg_ready !== 1'b1)) early_bad = 1'b1;
      if (i == 2) step();  // a cfg_valid gap
    end
    check("load_no_early_commit", 64'(early_bad), 64'(1'b0));
    if (nbits == rows) begin
      check("load_done", 64'({o.cfg_done, o.cfg_ready}), 64'(2'b10));
      step();
      o = sample(w);
      check("load_done_pulse", 64'(o.cfg_done), 64'(1'b0));
    end
  endtask

  task automatic sweep(input int w, input logic [63:0] tbl, input int rst_at);
    int   rows = 1 << w;
    int   cnt  = 0;
    obs_t o;
    drive(w, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    step();
    idle(w);
    for (int r = 0; r < rows; r++) begin
      o = sample(w);
      cnt += int'(tbl[r]);
      check("sweep_row",
            64'({o.out_valid, o.sweep_busy, o.sweep_done, o.eval_ready, o.out, o.out_row}),
            64'({1'b1, 1'b1, (r == rows - 1), 1'b0, tbl[r], 8'(r)}));
      if (r == rows - 1 || r == rst_at)
        check("sweep_ones", 64'(o.ones_count), 64'(9'(cnt)));
      if (r == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        o = sample(w);
        check("async_reset",
              64'({o.cfg_ready, o.cfg_done, o.sweep_busy, o.sweep_done,
                   o.out_valid, o.out, o.out_row, o.ones_count}), 64'(0));
        step();
        step();
        o = sample(w);
        check("reset_hold", 64'({o.sweep_done, o.sweep_busy, o.out_valid}), 64'(3'b000));
        rst_n = 1'b1;
        step();
        return;
      end
      step();
    end
    o = sample(w);
    check("sweep_end", 64'({o.out_valid, o.sweep_busy, o.sweep_done, o.ones_count}),
          64'({3'b000, 9'(cnt)}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    idle(4);
    idle(2);
    idle(6);
    rst_n = 1'b0;
    step();
    step();

    // Reset state, then every row of the power-up table reads 0.
    cur_n = 4;
    o = sample(4);
    check("reset_state",
          64'({o.cfg_ready, o.cfg_done, o.sweep_busy, o.sweep_done,
               o.out_valid, o.out, o.out_row, o.ones_count}), 64'(0));
    rst_n = 1'b1;
    step();
    for (int r = 0; r < 16; r++) eval(4, r, 1'b0);

    // Rows 10..12 set.
    load(4, 64'h1C00, 16, 1'b1, -1, 0, 1'b0);
    eval(4, 10, 1'b1);
    eval(4, 13, 1'b0);
    sweep(4, 64'h1C00, -1);

    // Abort after 7 bits (eval mid-load sees the old table), then all-ones.
    load(4, 64'h1234, 7, 1'b1, 6, 10, 1'b1);
    load(4, 64'hFFFF, 16, 1'b1, -1, 0, 1'b0);
    sweep(4, 64'hFFFF, -1);

    // Eval on the committing edge still uses the old all-ones table.
    load(4, 64'h8001, 16, 1'b1, 15, 7, 1'b1);
    eval(4, 7, 1'b0);
    eval(4, 15, 1'b1);

    // cfg_start + sweep_start + eval together: LOAD wins, nothing else starts.
    drive(4, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3, 1'b1);
    #1;
    o = sample(4);
    check("both_eval_ready", 64'(o.eval_ready), 64'(1'b0));
    step();
    drive(4, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    o = sample(4);
    check("both_enter_load", 64'({o.cfg_ready, o.sweep_busy, o.out_valid}), 64'(3'b100));
    step();
    idle(4);
    o = sample(4);
    check("load_ignores_sweep", 64'({o.cfg_ready, o.sweep_busy, o.out_valid}), 64'(3'b100));
    load(4, 64'h8001, 16, 1'b0, -1, 0, 1'b0);

    // Reset at sweep row 5 clears the table.
    sweep(4, 64'h8001, -1);
    sweep(4, 64'h8001, 5);
    eval(4, 15, 1'b0);
    sweep(4, 64'h0, -1);

    cur_n = 2;
    load(2, 64'hB, 4, 1'b1, -1, 0, 1'b0);
    eval(2, 2, 1'b0);
    eval(2, 3, 1'b1);
    sweep(2, 64'hB, -1);
    sweep(2, 64'hB, 2);
    sweep(2, 64'h0, -1);

    cur_n = 6;
    load(6, 64'h8000_0000_0000_0021, 64, 1'b1, -1, 0, 1'b0);
    eval(6, 5, 1'b1);
    eval(6, 6, 1'b0);
    eval(6, 63, 1'b1);
    sweep(6, 64'h8000_0000_0000_0021, -1);
    sweep(6, 64'h8000_0000_0000_0021, 5);
    eval(6, 63, 1'b0);
    sweep(6, 64'h0, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
`default_nettype wire
